// File: rtl/sram_bist_pkg.sv
// -----------------------------------------------------------------------------
// sram_bist_pkg
// Shared types and constants for the SRAM March C- BIST initiator.
//   - state_e       : controller states
//   - elem_t        : March element index (0..5)
//   - ELEM_*        : per-element constant tables, bit i describes element i
// -----------------------------------------------------------------------------
package sram_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned NUM_ELEM = 6;

   typedef logic [2:0] elem_t;

   localparam elem_t FIRST_ELEM = 3'd0;
   localparam elem_t LAST_ELEM  = elem_t'(NUM_ELEM - 1);

   // March C-:  E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
   // Polarity 1 means the complemented background (D1).
   localparam logic [NUM_ELEM-1:0] ELEM_DOWN   = 6'b011000;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_RD = 6'b111110;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_WR = 6'b011111;
   localparam logic [NUM_ELEM-1:0] ELEM_RD_POL = 6'b010100;
   localparam logic [NUM_ELEM-1:0] ELEM_WR_POL = 6'b001010;

endpackage

// File: rtl/sram_bist_checker.sv
// -----------------------------------------------------------------------------
// sram_bist_checker
// Compare pipeline and failure logging for the March BIST.
// A read driven to the bank in cycle k has its expected word, address and
// element registered here at the end of cycle k; the bank's latched data is
// compared against them during cycle k+1.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear_i           run start: clears fail state and counter
//   rd_i              a bank read is being driven this cycle
//   elem_i, addr_i    element and address of the driven request
//   dataout_i         bank latched read data
//   fail_o            sticky mismatch flag
//   fail_addr_o/elem_o/exp_o/act_o  first-mismatch record
//   err_count_o       saturating mismatch count
// -----------------------------------------------------------------------------
module sram_bist_checker
   import sram_bist_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ERRCNT_W = 12,
   parameter logic [DATA_W-1:0] BG       = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                rd_i,
   input  elem_t               elem_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   dataout_i,
   output logic                fail_o,
   output logic [ADDR_W-1:0]   fail_addr_o,
   output elem_t               fail_elem_o,
   output logic [DATA_W-1:0]   fail_exp_o,
   output logic [DATA_W-1:0]   fail_act_o,
   output logic [ERRCNT_W-1:0] err_count_o
);

   logic                vld_q;
   logic [DATA_W-1:0]   exp_q;
   logic [ADDR_W-1:0]   paddr_q;
   elem_t               pelem_q;

   logic                fail_q;
   logic [ADDR_W-1:0]   faddr_q;
   elem_t               felem_q;
   logic [DATA_W-1:0]   fexp_q;
   logic [DATA_W-1:0]   fact_q;
   logic [ERRCNT_W-1:0] cnt_q;

   logic                mismatch;

   assign mismatch = vld_q && (dataout_i != exp_q);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all flops so every register samples
      // pre-edge values regardless of statement or block order.
      if (reset || clear_i) begin
         vld_q <= 1'b0;
      end else begin
         vld_q <= rd_i;
      end
   end

   // NOTE: payload registers carry no reset; they are only consumed when
   // vld_q is set, which is itself reset.
   always_ff @(posedge clk) begin
      if (rd_i) begin
         exp_q   <= ELEM_RD_POL[elem_i] ? ~BG : BG;
         paddr_q <= addr_i;
         pelem_q <= elem_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         fail_q  <= 1'b0;
         faddr_q <= '0;
         felem_q <= '0;
         fexp_q  <= '0;
         fact_q  <= '0;
         cnt_q   <= '0;
      end else if (mismatch) begin
         if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // Only the first mismatch of a run is recorded.
         if (!fail_q) begin
            fail_q  <= 1'b1;
            faddr_q <= paddr_q;
            felem_q <= pelem_q;
            fexp_q  <= exp_q;
            fact_q  <= dataout_i;
         end
      end
   end

   assign fail_o      = fail_q;
   assign fail_addr_o = faddr_q;
   assign fail_elem_o = felem_q;
   assign fail_exp_o  = fexp_q;
   assign fail_act_o  = fact_q;
   assign err_count_o = cnt_q;

endmodule

// File: rtl/sram_march_bist.sv
// -----------------------------------------------------------------------------
// sram_march_bist
// March C- BIST initiator for one synchronous SRAM bank (2^ADDR_W x DATA_W).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   pulse; starts a run from IDLE or DONE
//   busy, done, pass, fail  run status (fail is sticky per run)
//   fail_addr/elem/exp/act  record of the first mismatch
//   err_count               saturating mismatch count
//   ADDRESS, wd             bank address and write data (registered)
//   banksel, read, write    bank enables (registered, never read & write)
//   dataout                 bank latched read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 16,
   parameter logic [DATA_W-1:0] BG       = '0,
   parameter int unsigned       ERRCNT_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [2:0]          fail_elem,
   output logic [DATA_W-1:0]   fail_exp,
   output logic [DATA_W-1:0]   fail_act,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [ADDR_W-1:0]   ADDRESS,
   output logic [DATA_W-1:0]   wd,
   output logic                banksel,
   output logic                read,
   output logic                write,
   input  logic [DATA_W-1:0]   dataout
);

   localparam logic [ADDR_W-1:0] ADDR_MIN = '0;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_e            state_q;
   elem_t             elem_q;
   logic [ADDR_W-1:0] addr_q;
   logic              phase_q;   // 0: read (or single op) slot, 1: write slot
   logic              rd_q;
   logic              wr_q;
   logic              sel_q;
   logic [DATA_W-1:0] wd_q;
   logic              busy_q;
   logic              done_q;

   elem_t             nxt_elem_d;
   logic [ADDR_W-1:0] nxt_addr_d;
   logic              nxt_phase_d;
   logic              nxt_rd_d;
   logic [DATA_W-1:0] nxt_wd_d;
   logic              run_end_d;
   logic              start_ok;

   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Next request of the March sequence, derived from the one being driven.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      nxt_elem_d  = elem_q;
      nxt_addr_d  = addr_q;
      nxt_phase_d = 1'b0;
      run_end_d   = 1'b0;

      if (ELEM_HAS_RD[elem_q] && ELEM_HAS_WR[elem_q] && !phase_q) begin
         nxt_phase_d = 1'b1;
      end else if (addr_q == (ELEM_DOWN[elem_q] ? ADDR_MIN : ADDR_MAX)) begin
         // Address wraps only here, when the element changes.
         if (elem_q == LAST_ELEM) begin
            run_end_d = 1'b1;
         end else begin
            nxt_elem_d = elem_q + 3'd1;
            nxt_addr_d = ELEM_DOWN[nxt_elem_d] ? ADDR_MAX : ADDR_MIN;
         end
      end else if (ELEM_DOWN[elem_q]) begin
         nxt_addr_d = addr_q - 1'b1;
      end else begin
         nxt_addr_d = addr_q + 1'b1;
      end

      nxt_rd_d = ELEM_HAS_RD[nxt_elem_d] && !nxt_phase_d;
      nxt_wd_d = ELEM_WR_POL[nxt_elem_d] ? ~BG : BG;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         elem_q  <= FIRST_ELEM;
         addr_q  <= '0;
         phase_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         sel_q   <= 1'b0;
         wd_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  state_q <= ST_RUN;
                  elem_q  <= FIRST_ELEM;
                  addr_q  <= '0;
                  phase_q <= 1'b0;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b1;
                  sel_q   <= 1'b1;
                  wd_q    <= BG;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (run_end_d) begin
                  state_q <= ST_FLUSH;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  sel_q   <= 1'b0;
                  wd_q    <= '0;
               end else begin
                  elem_q  <= nxt_elem_d;
                  addr_q  <= nxt_addr_d;
                  phase_q <= nxt_phase_d;
                  rd_q    <= nxt_rd_d;
                  wr_q    <= !nxt_rd_d;
                  sel_q   <= 1'b1;
                  wd_q    <= nxt_rd_d ? '0 : nxt_wd_d;
               end
            end
            ST_FLUSH: begin
               // The final read's compare happens during this cycle.
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   sram_bist_checker #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .ERRCNT_W (ERRCNT_W),
      .BG       (BG)
   ) u_checker (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (start_ok),
      .rd_i        (rd_q),
      .elem_i      (elem_q),
      .addr_i      (addr_q),
      .dataout_i   (dataout),
      .fail_o      (fail),
      .fail_addr_o (fail_addr),
      .fail_elem_o (fail_elem),
      .fail_exp_o  (fail_exp),
      .fail_act_o  (fail_act),
      .err_count_o (err_count)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = done_q && !fail;
   assign ADDRESS = addr_q;
   assign wd      = wd_q;
   assign banksel = sel_q;
   assign read    = rd_q;
   assign write   = wr_q;

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test initiator for one synchronous SRAM bank of 2^ADDR_W words of DATA_W bits.
- Drives the bank's request side (address, write data, bank select, read, write) and checks its latched read-data output.
- Runs the March C- algorithm, logs the first failure and counts all mismatches.
- Sits beside each bank in the array wrapper; the BIST mux selects between this block and functional traffic.

Parameters:
ADDR_W, 8, bank address width (depth = 2^ADDR_W = 256)
DATA_W, 16, bank word width
BG, 16'h0000, data background: "0" = BG, "1" = ~BG
ERRCNT_W, 12, width of the saturating mismatch counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a run when idle or done
busy  out  1  run in progress
done  out  1  run complete; held until next start or reset
pass  out  1  done & ~fail
fail  out  1  sticky; at least one mismatch this run
fail_addr  out  ADDR_W  address of first mismatch
fail_elem  out  3  March element (0..5) of first mismatch
fail_exp  out  DATA_W  expected word at first mismatch
fail_act  out  DATA_W  read word at first mismatch
err_count  out  ERRCNT_W  mismatches this run, saturating at all-ones
ADDRESS  out  ADDR_W  bank address
wd  out  DATA_W  bank write data
banksel  out  1  bank access enable
read  out  1  bank read enable
write  out  1  bank write enable
dataout  in  DATA_W  bank latched read data, valid the cycle after a read

Behaviour:
- Reset values: all outputs 0; FSM returns to IDLE, including from mid-run. Reset takes priority over start.
- All bank-side outputs are registered. read and write are never high in the same cycle. banksel = read | write.
- Elements, with D0 = BG and D1 = ~BG:
  - E0 up (w D0)
  - E1 up (r D0, w D1)
  - E2 up (r D1, w D0)
  - E3 down (r D0, w D1)
  - E4 down (r D1, w D0)
  - E5 up (r D0)
  - "up" runs address 0 -> 2^ADDR_W-1; "down" runs 2^ADDR_W-1 -> 0. The address counter wraps only at element boundaries.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE or DONE, start=1 at an edge: clear fail, err_count and fail_* fields. Enter RUN with E0 write to addr 0 driven in the next cycle, busy=1, done=0.
  - RUN, elements E1-E4: per address, one read cycle then one write cycle to the same address.
  - RUN, elements E0 and E5: one cycle per address.
  - RUN -> FLUSH after the last E5 read is issued. FLUSH lasts one cycle, all bank enables 0, and performs the final compare.
  - FLUSH -> DONE: busy=0, done=1.
- start while busy is ignored.
- Compare pipeline: a read issued in cycle k registers {expected, address, element} and is compared against dataout in cycle k+1. For E1-E4, cycle k+1 is that address's write cycle, so the pipeline never stalls.
- Mismatch handling:
  - err_count increments by 1 per mismatching word, saturating.
  - On the first mismatch of a run, fail_* are captured and then frozen.
  - The run always completes and never stops early.
- Latency: 256 + 4×512 + 256 = 2560 request cycles. done rises 2562 cycles after the start-sampling edge (ADDR_W = 8).

Decomposition:
- Package sram_bist_pkg holds:
  - state enum
  - element count (6)
  - per-element constant tables: direction, has_read, has_write, read polarity, write polarity
- One sub-module, sram_bist_checker, holds:
  - compare pipeline register
  - sticky fail
  - first-fail capture
  - saturating err_count

Test Plan:
- Fault-free bank model, BG=0: start at edge 0.
  - Required: busy=1 from cycle 1; 2560 cycles with banksel=1; no cycle with read&write.
  - Required: done=1 at cycle 2562; pass=1; err_count=0.
- Bit 3 stuck-at-1 at addr 0x2A:
  - Required: fail=1, fail_addr=0x2A, fail_elem=1, fail_exp=16'h0000, fail_act=16'h0008.
  - Required: err_count=3 (reads in E1, E3, E5); pass=0.
- Address order:
  - E0's first write goes to 0x00.
  - E3's first read targets 0xFF; its last write targets 0x00.
  - E5 ends at 0xFF.
- Reset asserted at cycle 1000:
  - Required: next cycle all outputs 0.
  - A fresh start runs the full 2562-cycle sequence from E0 addr 0.
- start pulsed at cycle 500 mid-run: ignored, done still at 2562. After a failing run, a new start clears fail and err_count at the same edge.
- BG=16'hA5A5:
  - E0 writes wd=16'hA5A5 and E1 writes 16'h5A5A.
  - Fault-free model gives pass=1.
